// File: rtl/ram_arb_pkg.sv
// Shared types and default timing for the Apple main-RAM SRAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } seqState_t;

    typedef enum logic [1:0] {
        REQ_CPU,
        REQ_VID,
        REQ_DMA
    } reqId_t;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_RD_CYCLES    = 2;
    localparam int DEF_WR_CYCLES    = 2;
    localparam int DEF_VID_MAX_WAIT = 8;

endpackage

// File: rtl/ram_access_sequencer.sv
// SRAM access sequencer: one read or write at a time, all strobes registered.
// Returns to IDLE for at least one cycle between accesses (bus turnaround).
module ram_access_sequencer
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic              clkMem,
    input  logic              rst_n,
    input  logic              start,
    input  logic              startWe,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [7:0]        startWdata,
    output logic              idle,
    output logic              finish,
    output logic              finishRd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [7:0]        ram_dout,
    output logic              ram_dout_en
);

    seqState_t  state, stateNext;
    logic [3:0] cnt, cntNext;
    logic       oeNNext, weNNext, doutEnNext;

    assign idle     = (state == IDLE);
    assign finishRd = finish && (state == RD);

    // Strobe values are computed for the next cycle so every pin comes from a flop.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        oeNNext    = 1'b1;
        weNNext    = 1'b1;
        doutEnNext = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cntNext = 4'd1;
                    if (startWe) begin
                        stateNext  = WR_SETUP;
                        doutEnNext = 1'b1;
                    end else begin
                        stateNext = RD;
                        oeNNext   = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt == 4'(RD_CYCLES)) begin
                    stateNext = IDLE;
                    finish    = 1'b1;
                end else begin
                    oeNNext = 1'b0;
                    cntNext = cnt + 4'd1;
                end
            end
            WR_SETUP: begin
                stateNext  = WR_PULSE;
                weNNext    = 1'b0;
                doutEnNext = 1'b1;
                cntNext    = 4'd1;
            end
            WR_PULSE: begin
                doutEnNext = 1'b1;
                if (cnt == 4'(WR_CYCLES)) begin
                    stateNext = WR_HOLD;
                end else begin
                    weNNext = 1'b0;
                    cntNext = cnt + 4'd1;
                end
            end
            WR_HOLD: begin
                stateNext = IDLE;
                finish    = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clkMem) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_dout_en <= 1'b0;
            ram_addr    <= '0;
            ram_dout    <= 8'h00;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            ram_oe_n    <= oeNNext;
            ram_we_n    <= weNNext;
            ram_dout_en <= doutEnNext;
            if (idle && start) begin
                ram_addr <= startAddr;
                if (startWe)
                    ram_dout <= startWdata;
            end
        end
    end

endmodule

// File: rtl/ram_chip_arbiter.sv
// Main-RAM arbiter: CPU / video / DMA share one async SRAM in the clkMem domain.
// Priority CPU > VID > DMA, with video promoted once it has waited VID_MAX_WAIT cycles.
module ram_chip_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RD_CYCLES    = DEF_RD_CYCLES,
    parameter int WR_CYCLES    = DEF_WR_CYCLES,
    parameter int VID_MAX_WAIT = DEF_VID_MAX_WAIT
) (
    input  logic              clkMem,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [7:0]        ram_dout,
    output logic              ram_dout_en,
    input  logic [7:0]        ram_din
);

    logic [7:0]        vidWait;
    logic              cpuPend, vidPend, dmaPend, vidUrgent, grant;
    reqId_t            winner, owner;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [7:0]        selWdata;
    logic              seqIdle, seqFinish, seqFinishRd;

    // A requester's req is still high in its own ack cycle; it must not re-win there.
    assign cpuPend   = cpu_req && !cpu_ack;
    assign vidPend   = vid_req && !vid_ack;
    assign dmaPend   = dma_req && !dma_ack;
    assign vidUrgent = (vidWait == 8'(VID_MAX_WAIT));

    always_comb begin
        grant  = 1'b0;
        winner = REQ_CPU;
        if (seqIdle) begin
            if (vidPend && vidUrgent) begin
                grant  = 1'b1;
                winner = REQ_VID;
            end else if (cpuPend) begin
                grant  = 1'b1;
                winner = REQ_CPU;
            end else if (vidPend) begin
                grant  = 1'b1;
                winner = REQ_VID;
            end else if (dmaPend) begin
                grant  = 1'b1;
                winner = REQ_DMA;
            end
        end
    end

    always_comb begin
        selWe    = cpu_we;
        selAddr  = cpu_addr;
        selWdata = cpu_wdata;
        case (winner)
            REQ_VID: begin
                selWe    = 1'b0;
                selAddr  = vid_addr;
                selWdata = 8'h00;
            end
            REQ_DMA: begin
                selWe    = dma_we;
                selAddr  = dma_addr;
                selWdata = dma_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkMem) begin
        if (!rst_n)
            vidWait <= 8'd0;
        else if (!vid_req || (grant && winner == REQ_VID))
            vidWait <= 8'd0;
        else if (!vidUrgent)
            vidWait <= vidWait + 8'd1;
    end

    always_ff @(posedge clkMem) begin
        if (!rst_n) begin
            owner     <= REQ_CPU;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
            vid_rdata <= 8'h00;
            dma_rdata <= 8'h00;
        end else begin
            if (grant)
                owner <= winner;
            cpu_ack <= seqFinish && (owner == REQ_CPU);
            vid_ack <= seqFinish && (owner == REQ_VID);
            dma_ack <= seqFinish && (owner == REQ_DMA);
            if (seqFinishRd) begin
                case (owner)
                    REQ_CPU: cpu_rdata <= ram_din;
                    REQ_VID: vid_rdata <= ram_din;
                    REQ_DMA: dma_rdata <= ram_din;
                    default: ;
                endcase
            end
        end
    end

    ram_access_sequencer #(
        .ADDR_W   (ADDR_W),
        .RD_CYCLES(RD_CYCLES),
        .WR_CYCLES(WR_CYCLES)
    ) uSeq (
        .clkMem     (clkMem),
        .rst_n      (rst_n),
        .start      (grant),
        .startWe    (selWe),
        .startAddr  (selAddr),
        .startWdata (selWdata),
        .idle       (seqIdle),
        .finish     (seqFinish),
        .finishRd   (seqFinishRd),
        .ram_addr   (ram_addr),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .ram_dout   (ram_dout),
        .ram_dout_en(ram_dout_en)
    );

endmodule

// File: tb/tb_ram_chip_arbiter.sv
// Directed bench for ram_chip_arbiter; RD/WR = 2 cycles, video wait limit lowered to 4.
module tb_ram_chip_arbiter;

    logic        clkMem = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, vid_req, dma_req, dma_we;
    logic [15:0] cpu_addr, vid_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_ack, vid_ack, dma_ack;
    logic [7:0]  cpu_rdata, vid_rdata, dma_rdata;
    logic [15:0] ram_addr;
    logic        ram_oe_n, ram_we_n, ram_dout_en;
    logic [7:0]  ram_dout, ram_din;
    logic        useFixed;
    logic [7:0]  fixedDin;

    int passCnt  = 0;
    int totalCnt = 0;

    // SRAM stand-in: data is a fixed function of the low address byte unless overridden.
    assign ram_din = useFixed ? fixedDin : (ram_addr[7:0] ^ 8'h3C);

    always #5 clkMem = ~clkMem;

    // Limit of 4 lets the video override occur at the end of a single DMA write.
    ram_chip_arbiter #(
        .ADDR_W(16), .RD_CYCLES(2), .WR_CYCLES(2), .VID_MAX_WAIT(4)
    ) dut (
        .clkMem(clkMem), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_dout(ram_dout), .ram_dout_en(ram_dout_en), .ram_din(ram_din)
    );

    task automatic tick();
        @(posedge clkMem);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        useFixed = 0; fixedDin = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (3) tick();
        totalCnt++;
        if ({ram_oe_n, ram_we_n, ram_dout_en} !== 3'b110)
            $display("FAIL reset_strobes: got %b want 110", {ram_oe_n, ram_we_n, ram_dout_en});
        else passCnt++;
        totalCnt++;
        if ({ram_addr, ram_dout} !== 24'h0)
            $display("FAIL reset_bus: got %h want 000000", {ram_addr, ram_dout});
        else passCnt++;
        totalCnt++;
        if ({cpu_ack, vid_ack, dma_ack, cpu_rdata, vid_rdata, dma_rdata} !== 27'h0)
            $display("FAIL reset_acks_rdata: got %h want 0",
                     {cpu_ack, vid_ack, dma_ack, cpu_rdata, vid_rdata, dma_rdata});
        else passCnt++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_cpu_read();
        useFixed = 1; fixedDin = 8'hA5;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0400;
        tick();
        totalCnt++;
        if ({ram_oe_n, ram_addr} !== {1'b0, 16'h0400})
            $display("FAIL rd_t1: got oe_n=%b addr=%h want 0/0400", ram_oe_n, ram_addr);
        else passCnt++;
        cpu_addr = 16'hFFFF;
        tick();
        totalCnt++;
        if ({ram_oe_n, ram_addr, cpu_ack} !== {1'b0, 16'h0400, 1'b0})
            $display("FAIL rd_t2: got oe_n=%b addr=%h ack=%b want 0/0400/0", ram_oe_n, ram_addr, cpu_ack);
        else passCnt++;
        tick();
        totalCnt++;
        if ({ram_oe_n, cpu_ack, cpu_rdata} !== {1'b1, 1'b1, 8'hA5})
            $display("FAIL rd_t3_ack: got oe_n=%b ack=%b rdata=%h want 1/1/a5", ram_oe_n, cpu_ack, cpu_rdata);
        else passCnt++;
        cpu_req = 0; fixedDin = 8'h00;
        tick();
        totalCnt++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 8'hA5})
            $display("FAIL rd_hold: got ack=%b rdata=%h want 0/a5", cpu_ack, cpu_rdata);
        else passCnt++;
        useFixed = 0;
    endtask

    task automatic test_cpu_write();
        // {oe_n, we_n, dout_en, cpu_ack} for cycles t+1 .. t+6
        logic [3:0] wrExp [6] = '{4'b1110, 4'b1010, 4'b1010, 4'b1110, 4'b1101, 4'b1100};
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdata = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            tick();
            totalCnt++;
            if ({ram_oe_n, ram_we_n, ram_dout_en, cpu_ack} !== wrExp[k])
                $display("FAIL wr_cycle%0d: got %b want %b", k + 1,
                         {ram_oe_n, ram_we_n, ram_dout_en, cpu_ack}, wrExp[k]);
            else passCnt++;
            if (k < 4) begin
                totalCnt++;
                if ({ram_addr, ram_dout} !== {16'h2000, 8'h5A})
                    $display("FAIL wr_data%0d: got %h/%h want 2000/5a", k + 1, ram_addr, ram_dout);
                else passCnt++;
            end
            if (cpu_ack) cpu_req = 0;
        end
        cpu_we = 0;
    endtask

    task automatic test_simultaneous();
        int cpuAt = -1, vidAt = -1, dmaAt = -1, viol = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1111;
        vid_req = 1; vid_addr = 16'h2222;
        dma_req = 1; dma_we = 0; dma_addr = 16'h3333;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (cpu_ack || vid_ack || dma_ack)
                if (!ram_oe_n || ram_dout_en) viol++;
            if (cpu_ack) begin cpuAt = k; cpu_req = 0; end
            if (vid_ack) begin vidAt = k; vid_req = 0; end
            if (dma_ack) begin dmaAt = k; dma_req = 0; end
        end
        totalCnt++;
        if ({cpuAt, vidAt, dmaAt} !== {32'sd3, 32'sd6, 32'sd9})
            $display("FAIL sim_order: got cpu=%0d vid=%0d dma=%0d want 3/6/9", cpuAt, vidAt, dmaAt);
        else passCnt++;
        totalCnt++;
        if ({cpu_rdata, vid_rdata, dma_rdata} !== {8'h2D, 8'h1E, 8'h0F})
            $display("FAIL sim_rdata: got %h %h %h want 2d 1e 0f", cpu_rdata, vid_rdata, dma_rdata);
        else passCnt++;
        totalCnt++;
        if (viol !== 0)
            $display("FAIL sim_idle_gap: got %0d busy ack cycles want 0", viol);
        else passCnt++;
    endtask

    task automatic test_starvation();
        int cpuFirst = -1, cpuSecond = -1, vidAt = -1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        vid_req = 1; vid_addr = 16'h0020;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (cpu_ack) begin
                if (cpuFirst < 0) cpuFirst = k;
                else begin cpuSecond = k; cpu_req = 0; end
            end
            if (vid_ack) begin vidAt = k; vid_req = 0; end
        end
        totalCnt++;
        if ({cpuFirst, vidAt, cpuSecond} !== {32'sd3, 32'sd6, 32'sd9})
            $display("FAIL starve_order: got cpu=%0d vid=%0d cpu2=%0d want 3/6/9", cpuFirst, vidAt, cpuSecond);
        else passCnt++;
        totalCnt++;
        if (vid_rdata !== 8'h1C)
            $display("FAIL starve_vid_rdata: got %h want 1c", vid_rdata);
        else passCnt++;
    endtask

    task automatic test_vid_override();
        int vidFirst = -1, vidSecond = -1, dmaAt = -1, cpuAt = -1;
        vid_req = 1; vid_addr = 16'h0040;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0050; dma_wdata = 8'h77;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 4) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0060; end
            if (vid_ack) begin
                if (vidFirst < 0) vidFirst = k;
                else begin vidSecond = k; vid_req = 0; end
            end
            if (dma_ack) begin dmaAt = k; dma_req = 0; end
            if (cpu_ack) begin cpuAt = k; cpu_req = 0; end
        end
        totalCnt++;
        if ({vidFirst, dmaAt} !== {32'sd3, 32'sd8})
            $display("FAIL ovr_prefix: got vid=%0d dma=%0d want 3/8", vidFirst, dmaAt);
        else passCnt++;
        totalCnt++;
        if ({vidSecond, cpuAt} !== {32'sd11, 32'sd14})
            $display("FAIL ovr_vid_first: got vid=%0d cpu=%0d want 11/14", vidSecond, cpuAt);
        else passCnt++;
        dma_we = 0;
    endtask

    task automatic test_turnaround();
        int dmaAt = -1, cpuAt = -1, viol = 0;
        logic oeAt6 = 1'b1;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0070; dma_wdata = 8'h99;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0080; end
            if (!ram_oe_n && ram_dout_en) viol++;
            if (k == 6) oeAt6 = ram_oe_n;
            if (dma_ack) begin dmaAt = k; dma_req = 0; end
            if (cpu_ack) begin cpuAt = k; cpu_req = 0; end
        end
        totalCnt++;
        if ({dmaAt, cpuAt} !== {32'sd5, 32'sd8})
            $display("FAIL turn_acks: got dma=%0d cpu=%0d want 5/8", dmaAt, cpuAt);
        else passCnt++;
        totalCnt++;
        if ({viol, oeAt6} !== {32'sd0, 1'b0})
            $display("FAIL turn_overlap: got viol=%0d oe_n@6=%b want 0/0", viol, oeAt6);
        else passCnt++;
        totalCnt++;
        if (cpu_rdata !== 8'hBC)
            $display("FAIL turn_rdata: got %h want bc", cpu_rdata);
        else passCnt++;
        dma_we = 0;
    endtask

    task automatic test_reset_mid_write();
        int ackSeen = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 8'hC3;
        tick();
        tick();
        totalCnt++;
        if (ram_we_n !== 1'b0)
            $display("FAIL rst_mid_pulse: got we_n=%b want 0", ram_we_n);
        else passCnt++;
        rst_n = 0;
        cpu_req = 0; cpu_we = 0;
        repeat (3) tick();
        totalCnt++;
        if ({ram_oe_n, ram_we_n, ram_dout_en, cpu_ack, vid_ack, dma_ack, ram_addr, cpu_rdata}
                !== {3'b110, 3'b000, 16'h0000, 8'h00})
            $display("FAIL rst_mid_state: got strobes=%b acks=%b addr=%h rdata=%h want 110/000/0000/00",
                     {ram_oe_n, ram_we_n, ram_dout_en}, {cpu_ack, vid_ack, dma_ack}, ram_addr, cpu_rdata);
        else passCnt++;
        rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cpu_ack || vid_ack || dma_ack || !ram_we_n) ackSeen++;
        end
        totalCnt++;
        if (ackSeen !== 0)
            $display("FAIL rst_mid_no_ack: got %0d active cycles want 0", ackSeen);
        else passCnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_simultaneous();
        test_starvation();
        test_vid_override();
        test_turnaround();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
